// File: rtl/ldpc_phase_sched_if.sv
// Control/status bundle between the LDPC phase scheduler and its frame controller.
// The master side is the scheduler; the slave side issues start pulses.
interface ldpc_phase_sched_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic                  busy;
  logic                  vnu_en;
  logic                  enable_cnu;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_valid;
  logic                  ag_reset;
  logic                  f_id;
  logic [7:0]            iter_cnt;
  logic                  frame_done;

  modport master (
    input  start,
    output busy, vnu_en, enable_cnu, addr, addr_valid, ag_reset,
           f_id, iter_cnt, frame_done
  );

  modport slave (
    output start,
    input  busy, vnu_en, enable_cnu, addr, addr_valid, ag_reset,
           f_id, iter_cnt, frame_done
  );
endinterface

// File: rtl/ldpc_phase_sched.sv
// LDPC layered-decoder phase scheduler: alternates CNU and VNU address sweeps with
// pipeline drains for MAX_ITER iterations, then swaps the frame bank.
module ldpc_phase_sched #(
  parameter int L          = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNU_DELAY  = 5,
  parameter int VNU_DELAY  = 3,
  parameter int MAX_ITER   = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  ldpc_phase_sched_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, CNU_ISSUE, CNU_DRAIN, VNU_ISSUE, VNU_DRAIN, SWAP
  } state_t;

  localparam int MAX_DELAY = (CNU_DELAY > VNU_DELAY) ? CNU_DELAY : VNU_DELAY;
  localparam int DW        = $clog2(MAX_DELAY + 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(L - 1);
  localparam logic [DW-1:0]         CNU_LAST  = DW'(CNU_DELAY);
  localparam logic [DW-1:0]         VNU_LAST  = DW'(VNU_DELAY);
  localparam logic [7:0]            ITER_LAST = 8'(MAX_ITER);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DW-1:0]         drain_reg, drain_next;
  logic [7:0]            iter_reg, iter_next;
  logic                  pending_reg, pending_next;
  logic                  f_id_reg, f_id_next;
  logic                  addr_valid_reg, addr_valid_next;
  logic                  ag_reset_reg, ag_reset_next;
  logic                  enable_cnu_reg, enable_cnu_next;
  logic                  vnu_en_reg, vnu_en_next;
  logic                  busy_reg, busy_next;
  logic                  frame_done_reg, frame_done_next;

  always_comb begin
    state_next   = state_reg;
    addr_next    = '0;
    drain_next   = drain_reg;
    iter_next    = iter_reg;
    pending_next = pending_reg;

    // SWAP consumes a start directly, so only mid-frame starts are latched.
    if (bus.start && (state_reg != IDLE) && (state_reg != SWAP))
      pending_next = 1'b1;

    case (state_reg)
      IDLE: begin
        if (bus.start)
          state_next = CNU_ISSUE;
      end
      CNU_ISSUE: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = CNU_DRAIN;
          drain_next = '0;
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
        end
      end
      CNU_DRAIN: begin
        if (drain_reg == CNU_LAST)
          state_next = VNU_ISSUE;
        else
          drain_next = drain_reg + DW'(1);
      end
      VNU_ISSUE: begin
        if (addr_reg == ADDR_LAST) begin
          state_next = VNU_DRAIN;
          drain_next = '0;
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
        end
      end
      VNU_DRAIN: begin
        if (drain_reg == VNU_LAST) begin
          iter_next  = iter_reg + 8'd1;
          state_next = ((iter_reg + 8'd1) == ITER_LAST) ? SWAP : CNU_ISSUE;
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      SWAP: begin
        iter_next    = '0;
        pending_next = 1'b0;
        state_next   = (pending_reg || bus.start) ? CNU_ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state so they stay registered and aligned.
    f_id_next       = (state_next == SWAP) ? ~f_id_reg : f_id_reg;
    addr_valid_next = (state_next == CNU_ISSUE) || (state_next == VNU_ISSUE);
    enable_cnu_next = (state_next == CNU_ISSUE) || (state_next == CNU_DRAIN);
    vnu_en_next     = (state_next == VNU_ISSUE) || (state_next == VNU_DRAIN);
    busy_next       = (state_next != IDLE);
    frame_done_next = (state_next == SWAP);
    ag_reset_next   = ((state_next == CNU_DRAIN) && (drain_next == CNU_LAST)) ||
                      ((state_next == VNU_DRAIN) && (drain_next == VNU_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      drain_reg      <= '0;
      iter_reg       <= '0;
      pending_reg    <= 1'b0;
      f_id_reg       <= 1'b0;
      addr_valid_reg <= 1'b0;
      ag_reset_reg   <= 1'b1;
      enable_cnu_reg <= 1'b0;
      vnu_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      drain_reg      <= drain_next;
      iter_reg       <= iter_next;
      pending_reg    <= pending_next;
      f_id_reg       <= f_id_next;
      addr_valid_reg <= addr_valid_next;
      ag_reset_reg   <= ag_reset_next;
      enable_cnu_reg <= enable_cnu_next;
      vnu_en_reg     <= vnu_en_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.vnu_en     = vnu_en_reg;
  assign bus.enable_cnu = enable_cnu_reg;
  assign bus.addr       = addr_reg;
  assign bus.addr_valid = addr_valid_reg;
  assign bus.ag_reset   = ag_reset_reg;
  assign bus.f_id       = f_id_reg;
  assign bus.iter_cnt   = iter_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_ldpc_phase_sched.sv
// Bench for ldpc_phase_sched: a small-parameter instance for scenario tests and a
// default-parameter instance for full-length frame timing.
module tb_ldpc_phase_sched;

  localparam int LA = 4, AWA = 3, CDA = 2, VDA = 1, MIA = 2;
  localparam int LB = 32, CDB = 5, VDB = 3, MIB = 18;

  typedef struct packed {
    logic [7:0] addr;
    logic       av;
    logic       ec;
    logic       ve;
    logic       agr;
    logic       busy;
    logic       fid;
    logic       fd;
    logic [7:0] iter;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;

  ldpc_phase_sched_if #(.ADDR_WIDTH(AWA)) ifa ();
  ldpc_phase_sched_if                     ifb ();

  ldpc_phase_sched #(
    .L(LA), .ADDR_WIDTH(AWA), .CNU_DELAY(CDA), .VNU_DELAY(VDA), .MAX_ITER(MIA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(ifa.master)
  );

  ldpc_phase_sched dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(ifb.master)
  );

  always #5 clk = ~clk;

  int   asserts = 0;
  int   fails   = 0;
  rec_t exp_q[$];

  function automatic rec_t mk(input int a, input logic av, input logic ec, input logic ve,
                              input logic agr, input logic busy, input logic fid,
                              input logic fd, input int it);
    rec_t r;
    r.addr = 8'(a);
    r.av   = av;
    r.ec   = ec;
    r.ve   = ve;
    r.agr  = agr;
    r.busy = busy;
    r.fid  = fid;
    r.fd   = fd;
    r.iter = 8'(it);
    return r;
  endfunction

  function automatic rec_t obs_a();
    return mk(int'(ifa.addr), ifa.addr_valid, ifa.enable_cnu, ifa.vnu_en, ifa.ag_reset,
              ifa.busy, ifa.f_id, ifa.frame_done, int'(ifa.iter_cnt));
  endfunction

  function automatic rec_t obs_b();
    return mk(int'(ifb.addr), ifb.addr_valid, ifb.enable_cnu, ifb.vnu_en, ifb.ag_reset,
              ifb.busy, ifb.f_id, ifb.frame_done, int'(ifb.iter_cnt));
  endfunction

  // Reference schedule: one frame is MAX_ITER x (CNU sweep, CNU drain, VNU sweep, VNU drain) then SWAP.
  task automatic push_frame(input int l, input int cd, input int vd, input int mi, input logic fid);
    for (int it = 0; it < mi; it++) begin
      for (int a = 0; a < l; a++)
        exp_q.push_back(mk(a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, fid, 1'b0, it));
      for (int d = 0; d <= cd; d++)
        exp_q.push_back(mk(0, 1'b0, 1'b1, 1'b0, d == cd, 1'b1, fid, 1'b0, it));
      for (int a = 0; a < l; a++)
        exp_q.push_back(mk(a, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, fid, 1'b0, it));
      for (int d = 0; d <= vd; d++)
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b1, d == vd, 1'b1, fid, 1'b0, it));
    end
    exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ~fid, 1'b1, mi));
  endtask

  task automatic push_idle(input int n, input logic fid);
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fid, 1'b0, 0));
  endtask

  task automatic do_reset_a();
    @(negedge clk);
    ifa.start = 1'b0;
    rst_n_a   = 1'b0;
    @(negedge clk);
    rst_n_a   = 1'b1;
  endtask

  task automatic test_reset();
    rec_t o;
    rec_t rst_rec;
    rec_t idle_rec;
    rst_rec  = mk(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_rec = mk(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst_n_a   = 1'b0;
    rst_n_b   = 1'b0;
    repeat (3) @(negedge clk);
    o = obs_a();
    asserts++;
    if (o !== rst_rec) begin fails++; $display("FAIL reset_a: got %p expected %p", o, rst_rec); end
    o = obs_b();
    asserts++;
    if (o !== rst_rec) begin fails++; $display("FAIL reset_b: got %p expected %p", o, rst_rec); end
    #2;
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    #1;
    asserts++;
    if (ifa.ag_reset !== 1'b1) begin
      fails++; $display("FAIL reset_release_hold: ag_reset=%b before first edge, expected 1", ifa.ag_reset);
    end
    @(posedge clk);
    #1;
    o = obs_a();
    asserts++;
    if (o !== idle_rec) begin fails++; $display("FAIL reset_first_edge_a: got %p expected %p", o, idle_rec); end
    o = obs_b();
    asserts++;
    if (o !== idle_rec) begin fails++; $display("FAIL reset_first_edge_b: got %p expected %p", o, idle_rec); end
    $display("test_reset done: %0d checks so far, %0d failures", asserts, fails);
  endtask

  task automatic test_single_frame();
    rec_t o;
    int   gap;
    int   fd_idx;
    gap = int'($urandom_range(0, 4));
    exp_q.delete();
    push_frame(LA, CDA, VDA, MIA, 1'b0);
    push_idle(3, 1'b1);
    repeat (gap + 1) @(posedge clk);
    #1 ifa.start = 1'b1;
    fd_idx = -1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1 ifa.start = 1'b0;
      @(negedge clk);
      o = obs_a();
      asserts++;
      if (o !== exp_q[k]) begin fails++; $display("FAIL single_trace[%0d]: got %p expected %p", k, o, exp_q[k]); end
      asserts++;
      if (o.ec && o.ve) begin fails++; $display("FAIL single_exclusive[%0d]: enable_cnu=1 vnu_en=1, expected not both", k); end
      asserts++;
      if (o.av && (o.addr >= 8'(LA))) begin fails++; $display("FAIL single_addr_range[%0d]: addr=%0d, expected < %0d", k, o.addr, LA); end
      if (o.fd && fd_idx < 0) fd_idx = k;
    end
    asserts++;
    if (fd_idx + 1 != 27) begin
      fails++; $display("FAIL single_done_latency: frame_done after %0d cycles, expected 27", fd_idx + 1);
    end
    $display("test_single_frame (gap %0d) done: %0d checks so far, %0d failures", gap, asserts, fails);
  endtask

  task automatic test_back_to_back();
    rec_t o;
    int   p1, p2, dn;
    do_reset_a();
    p1 = int'($urandom_range(0, 12));
    p2 = int'($urandom_range(p1 + 2, 24));
    exp_q.delete();
    push_frame(LA, CDA, VDA, MIA, 1'b0);
    push_frame(LA, CDA, VDA, MIA, 1'b1);
    push_idle(3, 1'b0);
    @(posedge clk);
    #1 ifa.start = 1'b1;
    dn = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1 ifa.start = (k == p1) || (k == p2);
      @(negedge clk);
      o = obs_a();
      asserts++;
      if (o !== exp_q[k]) begin fails++; $display("FAIL b2b_trace[%0d]: got %p expected %p", k, o, exp_q[k]); end
      asserts++;
      if (o.ec && o.ve) begin fails++; $display("FAIL b2b_exclusive[%0d]: enable_cnu=1 vnu_en=1, expected not both", k); end
      asserts++;
      if (o.av && (o.addr >= 8'(LA))) begin fails++; $display("FAIL b2b_addr_range[%0d]: addr=%0d, expected < %0d", k, o.addr, LA); end
      if (o.fd) dn++;
    end
    asserts++;
    if (dn != 2) begin fails++; $display("FAIL b2b_frame_count: %0d frame_done pulses, expected 2", dn); end
    $display("test_back_to_back (pulses at %0d,%0d) done: %0d checks so far, %0d failures", p1, p2, asserts, fails);
  endtask

  task automatic test_start_in_swap();
    rec_t o;
    int   swap_k;
    swap_k = MIA * (LA + CDA + 1 + LA + VDA + 1);
    exp_q.delete();
    push_frame(LA, CDA, VDA, MIA, 1'b0);
    push_frame(LA, CDA, VDA, MIA, 1'b1);
    push_idle(2, 1'b0);
    repeat (int'($urandom_range(1, 3))) @(posedge clk);
    #1 ifa.start = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1 ifa.start = (k == swap_k);
      @(negedge clk);
      o = obs_a();
      asserts++;
      if (o !== exp_q[k]) begin fails++; $display("FAIL swap_trace[%0d]: got %p expected %p", k, o, exp_q[k]); end
      asserts++;
      if (o.ec && o.ve) begin fails++; $display("FAIL swap_exclusive[%0d]: enable_cnu=1 vnu_en=1, expected not both", k); end
      asserts++;
      if (o.av && (o.addr >= 8'(LA))) begin fails++; $display("FAIL swap_addr_range[%0d]: addr=%0d, expected < %0d", k, o.addr, LA); end
    end
    $display("test_start_in_swap done: %0d checks so far, %0d failures", asserts, fails);
  endtask

  task automatic test_reset_mid_frame();
    rec_t o;
    rec_t rst_rec;
    int   target;
    rst_rec = mk(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    target  = LA + CDA + 1 + 2;
    exp_q.delete();
    push_frame(LA, CDA, VDA, MIA, 1'b0);
    @(posedge clk);
    #1 ifa.start = 1'b1;
    for (int k = 0; k <= target; k++) begin
      @(posedge clk);
      #1 ifa.start = (k == 3);
      @(negedge clk);
      o = obs_a();
      asserts++;
      if (o !== exp_q[k]) begin fails++; $display("FAIL midrst_trace[%0d]: got %p expected %p", k, o, exp_q[k]); end
    end
    #2 rst_n_a = 1'b0;
    #1;
    o = obs_a();
    asserts++;
    if (o !== rst_rec) begin fails++; $display("FAIL midrst_async: got %p expected %p", o, rst_rec); end
    @(posedge clk);
    #1;
    o = obs_a();
    asserts++;
    if (o !== rst_rec) begin fails++; $display("FAIL midrst_hold: got %p expected %p", o, rst_rec); end
    @(negedge clk);
    rst_n_a = 1'b1;
    exp_q.delete();
    push_idle(4, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      @(negedge clk);
      o = obs_a();
      asserts++;
      if (o !== exp_q[k]) begin fails++; $display("FAIL midrst_idle[%0d]: got %p expected %p", k, o, exp_q[k]); end
    end
    exp_q.delete();
    push_frame(LA, CDA, VDA, MIA, 1'b0);
    push_idle(1, 1'b1);
    @(posedge clk);
    #1 ifa.start = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1 ifa.start = 1'b0;
      @(negedge clk);
      o = obs_a();
      asserts++;
      if (o !== exp_q[k]) begin fails++; $display("FAIL midrst_restart[%0d]: got %p expected %p", k, o, exp_q[k]); end
      asserts++;
      if (o.ec && o.ve) begin fails++; $display("FAIL midrst_exclusive[%0d]: enable_cnu=1 vnu_en=1, expected not both", k); end
    end
    $display("test_reset_mid_frame done: %0d checks so far, %0d failures", asserts, fails);
  endtask

  task automatic test_default_params();
    rec_t o;
    int   cnu_len, vnu_len, fd_idx, max_iter;
    exp_q.delete();
    push_frame(LB, CDB, VDB, MIB, 1'b0);
    push_idle(2, 1'b1);
    repeat (int'($urandom_range(1, 5))) @(posedge clk);
    #1 ifb.start = 1'b1;
    cnu_len = 0; vnu_len = 0; fd_idx = -1; max_iter = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk);
      #1 ifb.start = 1'b0;
      @(negedge clk);
      o = obs_b();
      asserts++;
      if (o !== exp_q[k]) begin fails++; $display("FAIL default_trace[%0d]: got %p expected %p", k, o, exp_q[k]); end
      asserts++;
      if (o.ec && o.ve) begin fails++; $display("FAIL default_exclusive[%0d]: enable_cnu=1 vnu_en=1, expected not both", k); end
      asserts++;
      if (o.av && (o.addr >= 8'(LB))) begin fails++; $display("FAIL default_addr_range[%0d]: addr=%0d, expected < %0d", k, o.addr, LB); end
      if (o.ec === 1'b1 && o.iter == 8'd0) cnu_len++;
      if (o.ve === 1'b1 && o.iter == 8'd0) vnu_len++;
      if (o.fd === 1'b1 && fd_idx < 0) fd_idx = k;
      if (int'(o.iter) > max_iter) max_iter = int'(o.iter);
    end
    asserts++;
    if (cnu_len != 38) begin fails++; $display("FAIL default_cnu_phase: got %0d cycles, expected 38", cnu_len); end
    asserts++;
    if (vnu_len != 36) begin fails++; $display("FAIL default_vnu_phase: got %0d cycles, expected 36", vnu_len); end
    asserts++;
    if (fd_idx + 1 != 1333) begin fails++; $display("FAIL default_done_latency: got %0d cycles, expected 1333", fd_idx + 1); end
    asserts++;
    if (max_iter != 18) begin fails++; $display("FAIL default_iter_peak: got %0d, expected 18", max_iter); end
    $display("test_default_params done: %0d checks so far, %0d failures", asserts, fails);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, expected the bench to finish earlier");
    $fatal(1, "bench did not terminate in time");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_start_in_swap();
    test_reset_mid_frame();
    test_default_params();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
